// File: rtl/csr_bank.sv
// rtl/csr_bank.sv - machine-mode CSR bank with masked write/set/clear, 64-bit counters and timer irq
// Reads are combinational from pre-edge state; writes commit on the rising edge.
module csr_bank (
   input  logic        clk,
   input  logic        rst,
   input  logic        csr_w,
   input  logic [1:0]  csr_wsc_mode,
   input  logic [11:0] waddr,
   input  logic [31:0] wdata,
   input  logic [11:0] raddr,
   output logic [31:0] rdata,
   output logic [31:0] mstatus,
   input  logic        inst_retire,
   input  logic        timer_irq,
   output logic        irq_pending,
   output logic        raddr_illegal
);

   localparam logic [31:0] MISA_VAL       = 32'h4000_0100;
   localparam logic [31:0] MSTATUS_RST    = 32'h0000_1800;
   localparam logic [31:0] MSTATUS_WMASK  = 32'h0000_0088;
   localparam logic [31:0] MIE_WMASK      = 32'h0000_0888;
   localparam logic [31:0] ALIGN4_MASK    = 32'hFFFF_FFFC;

   logic [31:0] mstatus_q, mstatus_d;
   logic [31:0] mie_q, mie_d;
   logic [31:0] mtvec_q, mtvec_d;
   logic [31:0] mscratch_q, mscratch_d;
   logic [31:0] mepc_q, mepc_d;
   logic [31:0] mcause_q, mcause_d;
   logic [31:0] mtval_q, mtval_d;
   logic [63:0] mcycle_q, mcycle_d;
   logic [63:0] minstret_q, minstret_d;
   logic        irq_pending_q, irq_pending_d;

   logic [31:0] mip_val;
   logic [31:0] wold;
   logic [31:0] wval;
   logic        wr_en;

   assign mip_val     = {24'd0, timer_irq, 7'd0};
   assign wr_en       = csr_w && (csr_wsc_mode != 2'b00);
   assign mstatus     = mstatus_q;
   assign irq_pending = irq_pending_q;

   always_comb begin
      rdata         = 32'd0;
      raddr_illegal = 1'b0;
      case (raddr)
         12'h300: rdata = mstatus_q;
         12'h301: rdata = MISA_VAL;
         12'h304: rdata = mie_q;
         12'h305: rdata = mtvec_q;
         12'h340: rdata = mscratch_q;
         12'h341: rdata = mepc_q;
         12'h342: rdata = mcause_q;
         12'h343: rdata = mtval_q;
         12'h344: rdata = mip_val;
         12'hB00: rdata = mcycle_q[31:0];
         12'hB80: rdata = mcycle_q[63:32];
         12'hB02: rdata = minstret_q[31:0];
         12'hB82: rdata = minstret_q[63:32];
         default: raddr_illegal = 1'b1;
      endcase
   end

   // Old value at the write address feeds the set/clear read-modify-write.
   always_comb begin
      wold = 32'd0;
      case (waddr)
         12'h300: wold = mstatus_q;
         12'h304: wold = mie_q;
         12'h305: wold = mtvec_q;
         12'h340: wold = mscratch_q;
         12'h341: wold = mepc_q;
         12'h342: wold = mcause_q;
         12'h343: wold = mtval_q;
         12'hB00: wold = mcycle_q[31:0];
         12'hB80: wold = mcycle_q[63:32];
         12'hB02: wold = minstret_q[31:0];
         12'hB82: wold = minstret_q[63:32];
         default: wold = 32'd0;
      endcase
   end

   always_comb begin
      case (csr_wsc_mode)
         2'b01:   wval = wdata;
         2'b10:   wval = wold | wdata;
         2'b11:   wval = wold & ~wdata;
         default: wval = wold;
      endcase
   end

   always_comb begin
      mstatus_d  = mstatus_q;
      mie_d      = mie_q;
      mtvec_d    = mtvec_q;
      mscratch_d = mscratch_q;
      mepc_d     = mepc_q;
      mcause_d   = mcause_q;
      mtval_d    = mtval_q;
      mcycle_d   = mcycle_q + 64'd1;
      minstret_d = inst_retire ? (minstret_q + 64'd1) : minstret_q;
      if (wr_en) begin
         case (waddr)
            12'h300: mstatus_d  = (wval & MSTATUS_WMASK) | MSTATUS_RST;
            12'h304: mie_d      = wval & MIE_WMASK;
            12'h305: mtvec_d    = wval & ALIGN4_MASK;
            12'h340: mscratch_d = wval;
            12'h341: mepc_d     = wval & ALIGN4_MASK;
            12'h342: mcause_d   = wval;
            12'h343: mtval_d    = wval;
            // A counter write replaces the increment: the other half holds, no carry.
            12'hB00: mcycle_d   = {mcycle_q[63:32], wval};
            12'hB80: mcycle_d   = {wval, mcycle_q[31:0]};
            12'hB02: minstret_d = {minstret_q[63:32], wval};
            12'hB82: minstret_d = {wval, minstret_q[31:0]};
            default: ;
         endcase
      end
      irq_pending_d = mstatus_q[3] & mie_q[7] & timer_irq;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         mstatus_q     <= MSTATUS_RST;
         mie_q         <= 32'd0;
         mtvec_q       <= 32'd0;
         mscratch_q    <= 32'd0;
         mepc_q        <= 32'd0;
         mcause_q      <= 32'd0;
         mtval_q       <= 32'd0;
         mcycle_q      <= 64'd0;
         minstret_q    <= 64'd0;
         irq_pending_q <= 1'b0;
      end else begin
         mstatus_q     <= mstatus_d;
         mie_q         <= mie_d;
         mtvec_q       <= mtvec_d;
         mscratch_q    <= mscratch_d;
         mepc_q        <= mepc_d;
         mcause_q      <= mcause_d;
         mtval_q       <= mtval_d;
         mcycle_q      <= mcycle_d;
         minstret_q    <= minstret_d;
         irq_pending_q <= irq_pending_d;
      end
   end

endmodule

// File: doc/csr_bank.md
CSR_BANK -- requirements
Module: csr_bank

Interface
REQ-001 SHALL have ports: clk  in  1  rising-edge clock, the only clock.
REQ-002 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-003 SHALL have port csr_w  in  1  write request.
REQ-004 SHALL have port csr_wsc_mode  in  2  write mode: 00 none, 01 write, 10 set (OR), 11 clear (AND-NOT).
REQ-005 SHALL have port waddr  in  12  write CSR address.
REQ-006 SHALL have port wdata  in  32  write operand.
REQ-007 SHALL have port raddr  in  12  read CSR address.
REQ-008 SHALL have port rdata  out  32  read data, combinational.
REQ-009 SHALL have port mstatus  out  32  current mstatus, combinational.
REQ-010 SHALL have port inst_retire  in  1  one instruction retired this cycle.
REQ-011 SHALL have port timer_irq  in  1  machine timer interrupt level.
REQ-012 SHALL have port irq_pending  out  1  registered enabled-and-pending timer interrupt.
REQ-013 SHALL have port raddr_illegal  out  1  raddr maps to no implemented CSR, combinational.

Function
REQ-014 SHALL implement: mstatus 0x300, misa 0x301, mie 0x304, mtvec 0x305, mscratch 0x340, mepc 0x341, mcause 0x342, mtval 0x343, mip 0x344, mcycle 0xB00, mcycleh 0xB80, minstret 0xB02, minstreth 0xB82.
REQ-015 SHALL commit a write on the rising clk edge when csr_w=1 and csr_wsc_mode!=00; new = wdata (01), old|wdata (10), old&~wdata (11).
REQ-016 SHALL apply write masks: mstatus bits 3 (MIE) and 7 (MPIE) writable, bits 12:11 (MPP) fixed 11, all others 0; mie bits 3, 7, 11 writable, others 0; mtvec bits 1:0 fixed 00; mepc bits 1:0 fixed 00; mscratch, mcause, mtval, counters fully writable.
REQ-017 SHALL return misa = 0x40000100 constant; writes ignored.
REQ-018 SHALL return mip bit 7 = timer_irq of the current cycle, all other bits 0; writes ignored.
REQ-019 SHALL ignore writes to unimplemented addresses without side effects.
REQ-020 SHALL drive rdata from pre-edge state; same-cycle read of written address returns the old value (no bypass).
REQ-021 SHALL drive rdata = 0 and raddr_illegal = 1 for unimplemented raddr; raddr_illegal = 0 otherwise.
REQ-022 SHALL keep mcycle as 64-bit counter {mcycleh, mcycle}, +1 every cycle not in reset; wraps 0xFFFFFFFF_FFFFFFFF -> 0.
REQ-023 SHALL keep minstret as 64-bit counter, +1 per cycle with inst_retire=1; same wrap.
REQ-024 SHALL give a committed write to either half of a counter priority over the increment that cycle: written half takes the written value, other half holds (no increment, no carry).
REQ-025 SHALL apply low-half carry into high half in the same cycle (0x00000000_FFFFFFFF -> 0x00000001_00000000).
REQ-026 SHALL register irq_pending <= mstatus[3] & mie[7] & timer_irq, using pre-edge values (1-cycle latency).
REQ-027 SHALL drive mstatus output with the stored value including fixed bits.

Reset
REQ-028 SHALL on rst=1 at a rising edge set: mstatus 0x00001800, mie, mtvec, mscratch, mepc, mcause, mtval 0, both counters 0, irq_pending 0.
REQ-029 SHALL give rst priority over any same-cycle write and increment; first increment occurs on the first edge with rst=0.

Verification
REQ-030 SHALL cover: reset, then write mode 01 mtvec=0x00000107 -> next cycle read 0x00000104; same-cycle read returns 0.
REQ-031 SHALL cover: mstatus=0x1800, set mode 10 wdata=0x88, then clear mode 11 wdata=0x08 -> reads 0x1888 then 0x1880.
REQ-032 SHALL cover: write mcycle=0xFFFFFFFE, idle 2 cycles -> {mcycleh,mcycle} = 0x00000001_00000000.
REQ-033 SHALL cover: mstatus MIE=1, mie=0x80, timer_irq rises at edge N -> irq_pending 1 after edge N+1; clear MIE -> 0 one edge later.
REQ-034 SHALL cover: write 0xFFFFFFFF to misa, mip, 0x7C0 -> misa 0x40000100, mip = timer_irq<<7, raddr 0x7C0 reads 0 with raddr_illegal 1.
REQ-035 SHALL cover: rst asserted mid-count with simultaneous mepc write -> mepc 0, counters 0, irq_pending 0.
